ram_bank_pipe: RTL and testbench
================================

Name: ram_bank_pipe

Overview:
Parametrised successor to the single-cycle RAM bank: a simple dual-port (1W/1R) synchronous RAM with configurable read latency and a defined read-during-write collision policy. After reset, a hardware clear sequencer zeroes every word. A global enable stalls the whole read pipeline. It sits between the datapath producers and consumers wherever the plain bank lacked deterministic contents after reset or timing headroom.

Parameters:
ADDR_BIT, 3, address width of both ports
DATA_BIT, 16, word width
MEM_HEIGHT, 8, number of words (1 .. 2^ADDR_BIT)
RD_LAT, 1, read latency in cycles; legal values 1 or 2; others are an elaboration error
WRITE_FIRST, 1, collision policy: 1 returns new data, 0 returns old data
CLEAR_VAL, 0, DATA_BIT-wide value written to every word by the clear sequencer

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
en  in  1  global clock enable; 0 freezes RAM and pipeline
we  in  1  write request
re  in  1  read request
addr_w  in  ADDR_BIT  write address
d_w  in  DATA_BIT  write data
addr_r  in  ADDR_BIT  read address
d_r  out  DATA_BIT  read data, registered
rd_valid  out  1  d_r holds the result of a read issued RD_LAT enabled cycles earlier
busy  out  1  clear sequencer active; requests ignored
par_err  out  1  present only with RAM_PARITY_EN (see Optional Feature)

Behaviour:
- Reset (sampled on posedge while rst=1), regardless of en:
  - d_r=0, rd_valid=0, all pipeline stages invalid, busy=1.
  - FSM goes to CLEAR with clr_cnt=0.
  - RAM contents are not touched while rst is held.
- FSM states:
  - CLEAR: each posedge with en=1 writes CLEAR_VAL to mem[clr_cnt] and increments clr_cnt. The cycle writing index MEM_HEIGHT-1 moves to RUN. busy=1 throughout. en=0 pauses the count.
  - RUN: busy=0. The FSM stays in RUN until the next rst.
- Clear timing: with en=1 continuously, the first clear write happens on the first posedge after rst falls. busy falls after exactly MEM_HEIGHT cycles.
- Reset mid-CLEAR or in RUN restarts clearing from index 0.
- During CLEAR, we/re are ignored (no write, no read issued) and rd_valid=0.
- Write (RUN, en=1, we=1, addr_w<MEM_HEIGHT): mem[addr_w]<=d_w at posedge.
- Out-of-range write address: the write is dropped.
- Read (RUN, en=1, re=1):
  - Issued at posedge T.
  - RD_LAT=1: d_r/rd_valid updated at T; visible in cycle T+1.
  - RD_LAT=2: an extra output register stage; visible one enabled cycle later.
  - Out-of-range addr_r returns 0 with rd_valid=1.
- re=0 with en=1: a bubble enters the pipeline; rd_valid goes low at the matching output cycle. d_r holds its last value.
- en=0: no write, no read, no clear progress. All pipeline registers, d_r, rd_valid and clr_cnt hold.
- Collision (we=re=1, addr_w==addr_r, same cycle):
  - WRITE_FIRST=1: read returns d_w.
  - WRITE_FIRST=0: read returns the pre-write contents.
  - The write always lands.
- Back-to-back reads: one read per cycle, fully pipelined, no stalls.

Optional Feature:
RAM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit computed from d_w (and from CLEAR_VAL during clear).
  - The read path recomputes parity. par_err is asserted aligned with rd_valid when stored parity mismatches; it is 0 when rd_valid=0 and on reset.
  - A hidden test-only input is not added; mismatch injection is done by bench force on the memory array.
  - Out-of-range reads give par_err=0.
- Not defined: no parity storage, no par_err port; behaviour otherwise identical.

Test Plan:
1. Clear sequence (defaults): rst high 3 cycles, release with en=1 -> busy=1 for exactly 8 cycles then 0; reads of addresses 0..7 all return 0x0000 with rd_valid=1.
2. Fill/readback (RD_LAT=1, then RD_LAT=2): write d_w=addr*3 to addresses 0..7, then read 0..7 back-to-back -> d_r=0,3,...,21 on consecutive cycles, 1 (resp. 2) cycles after issue, rd_valid continuous.
3. Collision:
   - mem[3]=0x0003, then one cycle with we=re=1, addr_w=addr_r=3, d_w=0x000A.
   - WRITE_FIRST=1 -> d_r=0x000A.
   - WRITE_FIRST=0 -> d_r=0x0003, and a following read of 3 -> 0x000A.
4. Stall: issue reads of 1 and 2, drop en for 4 cycles mid-pipeline -> d_r/rd_valid frozen; on re-enable, 0x0003 then 0x0006 emerge with no loss or duplicate. Also drop en during CLEAR -> busy is extended by 4 cycles.
5. Reset mid-operation:
   - Write 0x1234 to address 5, then assert rst during CLEAR at clr_cnt=4 -> rd_valid=0 immediately.
   - Clearing restarts from 0, taking a full 8 cycles.
   - Afterwards address 5 reads 0x0000.
6. Boundary/parity:
   - MEM_HEIGHT=6: write to address 7 is dropped and reading 7 returns 0.
   - With RAM_PARITY_EN, force-flip a stored bit at address 2 -> par_err=1 with that read only.

Source files
------------

// File: rtl/ram_bank_pipe.sv
// Simple dual-port RAM with hardware clear after reset, 1- or 2-cycle read latency and a global stall.
// Optional RAM_PARITY_EN adds a stored even-parity bit per word and a par_err output.
module ram_bank_pipe #(
  parameter int ADDR_BIT    = 3,
  parameter int DATA_BIT    = 16,
  parameter int MEM_HEIGHT  = 8,
  parameter int RD_LAT      = 1,
  parameter int WRITE_FIRST = 1,
  parameter logic [DATA_BIT-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_BIT-1:0] addr_w,
  input  logic [DATA_BIT-1:0] d_w,
  input  logic [ADDR_BIT-1:0] addr_r,
  output logic [DATA_BIT-1:0] d_r,
  output logic                rd_valid,
  output logic                busy
`ifdef RAM_PARITY_EN
  ,
  output logic                par_err
`endif
);

`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_BIT + 1;
`else
  localparam int MEM_W = DATA_BIT;
`endif
  localparam logic [ADDR_BIT:0]   HEIGHT   = (ADDR_BIT+1)'(MEM_HEIGHT);
  localparam logic [ADDR_BIT-1:0] LAST_IDX = ADDR_BIT'(MEM_HEIGHT - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  logic [ADDR_BIT-1:0] clr_cnt;
  logic [MEM_W-1:0]    mem [MEM_HEIGHT];
  logic [MEM_W-1:0]    rd_word;
  logic [MEM_W-1:0]    rd_pay;
  logic                w_ok;
  logic                r_ok;
  logic                issue;

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_BIT-1:0] d);
`ifdef RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign w_ok  = {1'b0, addr_w} < HEIGHT;
  assign r_ok  = {1'b0, addr_r} < HEIGHT;
  assign issue = (state == RUN) && re;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else if (en) begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Contents are deliberately untouched while rst is held.
  always_ff @(posedge clk) begin
    if (!rst && en) begin
      if (state == CLEAR)
        mem[clr_cnt] <= encode(CLEAR_VAL);
      else if (we && w_ok)
        mem[addr_w] <= encode(d_w);
    end
  end

  // Payload carries the parity-error flag in its top bit when parity is built in.
  always_comb begin
    rd_word = '0;
    rd_pay  = '0;
    if (r_ok) begin
      rd_word = mem[addr_r];
`ifdef RAM_PARITY_EN
      rd_pay = {^rd_word, rd_word[DATA_BIT-1:0]};
`else
      rd_pay = rd_word;
`endif
      if (WRITE_FIRST != 0 && we && addr_w == addr_r)
        rd_pay = MEM_W'(d_w);
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_valid <= 1'b0;
          d_r      <= '0;
`ifdef RAM_PARITY_EN
          par_err  <= 1'b0;
`endif
        end else if (en) begin
          rd_valid <= issue;
          if (issue) d_r <= rd_pay[DATA_BIT-1:0];
`ifdef RAM_PARITY_EN
          par_err  <= issue & rd_pay[DATA_BIT];
`endif
        end
      end
    end else if (RD_LAT == 2) begin : g_lat2
      logic             s1_valid;
      logic [MEM_W-1:0] s1_pay;
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_pay   <= '0;
          rd_valid <= 1'b0;
          d_r      <= '0;
`ifdef RAM_PARITY_EN
          par_err  <= 1'b0;
`endif
        end else if (en) begin
          s1_valid <= issue;
          s1_pay   <= rd_pay;
          rd_valid <= s1_valid;
          if (s1_valid) d_r <= s1_pay[DATA_BIT-1:0];
`ifdef RAM_PARITY_EN
          par_err  <= s1_valid & s1_pay[DATA_BIT];
`endif
        end
      end
    end else begin : g_bad_lat
      $error("ram_bank_pipe: RD_LAT must be 1 or 2");
    end
  endgenerate

endmodule

// File: tb/tb_ram_bank_pipe.sv
// Bench for ram_bank_pipe: a default instance and a (RD_LAT=2, WRITE_FIRST=0, MEM_HEIGHT=6) instance
// share stimulus; both are checked every cycle against an array/delay-line model plus directed tables.
module tb_ram_bank_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0, en = 1'b0, we = 1'b0, re = 1'b0;
  logic [2:0]  addr_w = '0, addr_r = '0;
  logic [15:0] d_w = '0;
  logic [15:0] d_r_a, d_r_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b;
`ifdef RAM_PARITY_EN
  logic        par_err_a, par_err_b;
  logic        exp_perr_a = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_bank_pipe u_a (
    .clk(clk), .rst(rst), .en(en), .we(we), .re(re), .addr_w(addr_w), .d_w(d_w),
    .addr_r(addr_r), .d_r(d_r_a), .rd_valid(rd_valid_a), .busy(busy_a)
`ifdef RAM_PARITY_EN
    , .par_err(par_err_a)
`endif
  );

  ram_bank_pipe #(.RD_LAT(2), .WRITE_FIRST(0), .MEM_HEIGHT(6)) u_b (
    .clk(clk), .rst(rst), .en(en), .we(we), .re(re), .addr_w(addr_w), .d_w(d_w),
    .addr_r(addr_r), .d_r(d_r_b), .rd_valid(rd_valid_b), .busy(busy_b)
`ifdef RAM_PARITY_EN
    , .par_err(par_err_b)
`endif
  );

  // Reference model, one slot per instance
  int          h_k[2]   = '{8, 6};
  int          lat_k[2] = '{1, 2};
  bit          wf_k[2]  = '{1'b1, 1'b0};
  logic [15:0] mem_m[2][8];
  bit          clearing[2];
  int          clr[2];
  bit          line_v[2][2];
  logic [15:0] line_d[2][2];
  bit          ev[2];
  logic [15:0] ed[2];
  bit          modeled = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    bit          v;
    logic [15:0] val;
    if (rst) begin
      modeled     = 1'b1;
      clearing[k] = 1'b1;
      clr[k]      = 0;
      line_v[k][0] = 1'b0;
      line_v[k][1] = 1'b0;
      ev[k]       = 1'b0;
      ed[k]       = '0;
    end else if (en) begin
      v   = 1'b0;
      val = '0;
      if (!clearing[k] && re) begin
        v = 1'b1;
        if (int'(addr_r) < h_k[k])
          val = (wf_k[k] && we && addr_w == addr_r) ? d_w : mem_m[k][addr_r];
      end
      if (clearing[k]) begin
        mem_m[k][clr[k]] = '0;
        clr[k]++;
        if (clr[k] == h_k[k]) clearing[k] = 1'b0;
      end else if (we && int'(addr_w) < h_k[k]) begin
        mem_m[k][addr_w] = d_w;
      end
      line_v[k][1] = line_v[k][0];
      line_d[k][1] = line_d[k][0];
      line_v[k][0] = v;
      line_d[k][0] = val;
      ev[k] = line_v[k][lat_k[k]-1];
      if (ev[k]) ed[k] = line_d[k][lat_k[k]-1];
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    if (modeled) begin
      check("a_busy", 32'(busy_a), 32'(clearing[0]));
      check("a_valid", 32'(rd_valid_a), 32'(ev[0]));
      check("a_d_r", 32'(d_r_a), 32'(ed[0]));
      check("b_busy", 32'(busy_b), 32'(clearing[1]));
      check("b_valid", 32'(rd_valid_b), 32'(ev[1]));
      check("b_d_r", 32'(d_r_b), 32'(ed[1]));
`ifdef RAM_PARITY_EN
      check("a_par_err", 32'(par_err_a), 32'(exp_perr_a));
      check("b_par_err", 32'(par_err_b), 32'd0);
`endif
    end
  endtask

  task automatic idle();
    rst = 1'b0; en = 1'b1; we = 1'b0; re = 1'b0;
  endtask

  // Ticks until instance A drops busy, bounded; returns the tick count
  task automatic run_clear(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_a && n < 40);
  endtask

  typedef struct {
    logic        en, we, re;
    logic [2:0]  aw;
    logic [15:0] dw;
    logic [2:0]  ar;
    logic        exp_v;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n, nb;
    vecs[0]  = '{1, 1, 0, 3'd3, 16'h0003, 3'd0, 0, 16'h0015};
    vecs[1]  = '{1, 1, 1, 3'd3, 16'h000A, 3'd3, 1, 16'h000A};
    vecs[2]  = '{1, 0, 1, 3'd0, 16'h0000, 3'd3, 1, 16'h000A};
    vecs[3]  = '{1, 1, 1, 3'd7, 16'h0BEE, 3'd0, 1, 16'h0000};
    vecs[4]  = '{1, 0, 1, 3'd0, 16'h0000, 3'd7, 1, 16'h0BEE};
    vecs[5]  = '{1, 1, 1, 3'd5, 16'h1234, 3'd5, 1, 16'h1234};
    vecs[6]  = '{1, 0, 0, 3'd0, 16'h0000, 3'd0, 0, 16'h1234};
    vecs[7]  = '{0, 0, 1, 3'd0, 16'h0000, 3'd1, 0, 16'h1234};
    vecs[8]  = '{1, 0, 1, 3'd0, 16'h0000, 3'd1, 1, 16'h0003};
    vecs[9]  = '{0, 1, 1, 3'd1, 16'hFFFF, 3'd1, 1, 16'h0003};
    vecs[10] = '{1, 0, 1, 3'd0, 16'h0000, 3'd1, 1, 16'h0003};
    vecs[11] = '{1, 1, 1, 3'd6, 16'h5555, 3'd6, 1, 16'h5555};

    // Reset and clear timing
    rst = 1'b1; en = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy_a), 32'd1);
    check("rst_valid", 32'(rd_valid_a), 32'd0);
    check("rst_d_r", 32'(d_r_a), 32'd0);
    idle();
    n = 0; nb = 0;
    do begin
      tick();
      n++;
      if (!busy_b && nb == 0) nb = n;
    end while (busy_a && n < 40);
    check("clear_len_a", 32'(n), 32'd8);
    check("clear_len_b", 32'(nb), 32'd6);

    for (int i = 0; i < 8; i++) begin
      re = 1'b1; addr_r = 3'(i);
      tick();
      check("clear_read", 32'({rd_valid_a, d_r_a}), 32'h1_0000);
    end
    idle(); tick();

    // Fill with addr*3 and read back-to-back
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; addr_w = 3'(i); d_w = 16'(i * 3);
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      re = 1'b1; addr_r = 3'(i);
      tick();
      check("fill_a", 32'({rd_valid_a, d_r_a}), 32'h1_0000 | 32'(i * 3));
      if (i > 0)
        check("fill_b", 32'({rd_valid_b, d_r_b}), 32'h1_0000 | ((i - 1) < 6 ? 32'((i - 1) * 3) : 32'd0));
    end
    idle(); tick();
    check("fill_b_oob", 32'({rd_valid_b, d_r_b}), 32'h1_0000);

    // Directed vectors: collisions, out-of-range, bubbles, stalls
    foreach (vecs[i]) begin
      en = vecs[i].en; we = vecs[i].we; re = vecs[i].re;
      addr_w = vecs[i].aw; d_w = vecs[i].dw; addr_r = vecs[i].ar;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(rd_valid_a), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_d_r", i), 32'(d_r_a), 32'(vecs[i].exp_d));
    end

    // Stall with reads in flight
    idle();
    re = 1'b1; addr_r = 3'd1; tick();
    addr_r = 3'd2; tick();
    en = 1'b0; addr_r = 3'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_a", 32'({rd_valid_a, d_r_a}), 32'h1_0006);
      check("stall_b", 32'({rd_valid_b, d_r_b}), 32'h1_0003);
    end
    idle(); tick();
    check("resume_a", 32'({rd_valid_a, d_r_a}), 32'h0_0006);
    check("resume_b", 32'({rd_valid_b, d_r_b}), 32'h1_0006);
    tick();
    check("drain_b", 32'({rd_valid_b, d_r_b}), 32'h0_0006);

    // Clear paused by en
    rst = 1'b1; tick(); idle();
    repeat (2) tick();
    en = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    run_clear(n);
    check("clear_stalled_len", 32'(n + 6), 32'd12);

    // Reset in the middle of clearing
    we = 1'b1; addr_w = 3'd5; d_w = 16'h1234; tick(); idle();
    rst = 1'b1; tick(); idle();
    repeat (4) tick();
    rst = 1'b1; tick();
    check("midclr_valid", 32'(rd_valid_a), 32'd0);
    check("midclr_busy", 32'(busy_a), 32'd1);
    idle();
    run_clear(n);
    check("reclear_len", 32'(n), 32'd8);
    re = 1'b1; addr_r = 3'd5; tick();
    check("reclear_read5", 32'({rd_valid_a, d_r_a}), 32'h1_0000);
    idle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 249) == 0);
      en     = ($urandom_range(0, 7) != 0);
      we     = $urandom_range(0, 1) == 1;
      re     = $urandom_range(0, 1) == 1;
      addr_w = 3'($urandom_range(0, 7));
      addr_r = ($urandom_range(0, 3) == 0) ? addr_w : 3'($urandom_range(0, 7));
      d_w    = 16'($urandom);
      tick();
    end

`ifdef RAM_PARITY_EN
    rst = 1'b1; tick(); idle();
    run_clear(n);
    check("par_clear_len", 32'(n), 32'd8);
    we = 1'b1; addr_w = 3'd2; d_w = 16'h00C3; tick(); idle();
    u_a.mem[2][16] = ~u_a.mem[2][16];
    re = 1'b1; addr_r = 3'd2; exp_perr_a = 1'b1; tick();
    exp_perr_a = 1'b0;
    addr_r = 3'd3; tick();
    idle();
    we = 1'b1; addr_w = 3'd2; d_w = 16'h00C3; tick(); idle();
    re = 1'b1; addr_r = 3'd2; tick();
    idle(); tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
